usb_rw_burst_engine: RTL and testbench

Parametrised host-side read/write transaction engine; successor to the single-word read/write FSM.
- Sends an address OUT transaction, then 1..BURST_MAX data transactions: IN beats for reads, OUT beats for writes.
- Retries failed transactions up to MAX_RETRY attempts.
- Sits between the OS request interface and the USB protocol layer, which drives per-transaction success/failure.

---
 rtl/usb_rw_pkg.sv | 25 ++
 rtl/usb_rw_retry_ctr.sv | 64 ++++++
 rtl/usb_rw_burst_engine.sv | 153 +++++++++++++++
 tb/tb_usb_rw_burst_engine.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rw_pkg.sv
// Shared types for the USB read/write burst engine: FSM states, transaction
// kinds and the derived beat-count width.
package usb_rw_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    TURN     = 3'd2,
    DATA_OUT = 3'd3,
    DATA_IN  = 3'd4,
    FIN      = 3'd5
  } rw_state_e;

  // Kind of transaction the engine issues when it leaves TURN.
  typedef enum logic [1:0] {
    BEAT_ADDR = 2'd0,
    BEAT_OUT  = 2'd1,
    BEAT_IN   = 2'd2
  } beat_e;

  function automatic int len_width(input int burst_max);
    return $clog2(burst_max + 1);
  endfunction

endpackage

// File: rtl/usb_rw_retry_ctr.sv
// Per-transaction attempt counter with exhaustion flag. Optional response
// watchdog enabled by USB_RW_TIMEOUT_EN.
module usb_rw_retry_ctr
  import usb_rw_pkg::*;
#(
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clear,
  input  logic active,
  input  logic txn_success,
  input  logic txn_failure,
  output logic success,
  output logic fail_any,
  output logic exhausted
);

  localparam int CNT_W = $clog2(MAX_RETRY + 1);

  logic [CNT_W-1:0] attempts;
  logic             timeout;

  // Protocol responses only count while a transaction is on the bus;
  // success outranks a simultaneous failure.
  assign success = active && txn_success;

`ifdef USB_RW_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd;

  assign timeout = active && (wd == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wd <= '0;
    end else if (!active || success || fail_any) begin
      wd <= '0;
    end else begin
      wd <= wd + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign fail_any  = active && (txn_failure || timeout) && !txn_success;
  assign exhausted = fail_any && (attempts == CNT_W'(MAX_RETRY - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      attempts <= '0;
    end else if (clear || success || exhausted) begin
      attempts <= '0;
    end else if (fail_any) begin
      attempts <= attempts + 1'b1;
    end
  end

endmodule

// File: rtl/usb_rw_burst_engine.sv
// Host-side burst engine: address OUT, then 1..BURST_MAX IN/OUT data beats,
// each retried up to MAX_RETRY times. Optional watchdog: USB_RW_TIMEOUT_EN.
module usb_rw_burst_engine
  import usb_rw_pkg::*;
#(
  parameter  int DATA_W      = 64,
  parameter  int ADDR_W      = 16,
  parameter  int BURST_MAX   = 4,
  parameter  int MAX_RETRY   = 3,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int LEN_W       = len_width(BURST_MAX)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] data_to_device,
  input  logic [DATA_W-1:0] data_from_device,
  output logic              out_trans,
  output logic              in_trans,
  input  logic              txn_success,
  input  logic              txn_failure,
  output logic              done,
  output logic              ok,
  output logic [LEN_W-1:0]  beats_done
);

  rw_state_e        state, state_next;
  beat_e            beat;
  logic             fresh;
  logic             write_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_eff;
  logic             accept;
  logic             active;
  logic             success;
  logic             fail_any;
  logic             exhausted;
  logic             last_beat;

  assign accept    = req_valid && req_ready;
  assign active    = out_trans || in_trans;
  assign last_beat = (beats_done + LEN_W'(1)) == len_q;

  always_comb begin
    len_eff = req_len;
    if (req_len == '0) begin
      len_eff = LEN_W'(1);
    end else if (req_len > LEN_W'(BURST_MAX)) begin
      len_eff = LEN_W'(BURST_MAX);
    end
  end

  usb_rw_retry_ctr #(
    .MAX_RETRY  (MAX_RETRY),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_retry (
    .clk        (clk),
    .rst_b      (rst_b),
    .clear      (accept),
    .active     (active),
    .txn_success(txn_success),
    .txn_failure(txn_failure),
    .success    (success),
    .fail_any   (fail_any),
    .exhausted  (exhausted)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    req_ready  = (state == IDLE);
    out_trans  = (state == ADDR) || (state == DATA_OUT);
    in_trans   = (state == DATA_IN);
    done       = (state == FIN);
    wr_pop     = 1'b0;
    unique case (state)
      IDLE: if (req_valid) state_next = ADDR;
      ADDR, DATA_OUT, DATA_IN: begin
        if (success) begin
          state_next = (state != ADDR && last_beat) ? FIN : TURN;
        end else if (fail_any) begin
          state_next = exhausted ? FIN : TURN;
        end
      end
      TURN: begin
        unique case (beat)
          BEAT_ADDR: state_next = ADDR;
          BEAT_OUT:  state_next = DATA_OUT;
          default:   state_next = DATA_IN;
        endcase
        // Pop only for a fresh write beat; a reset edge consumes nothing.
        wr_pop = rst_b && (beat == BEAT_OUT) && fresh;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state          <= IDLE;
      beat           <= BEAT_ADDR;
      fresh          <= 1'b0;
      write_q        <= 1'b0;
      len_q          <= '0;
      data_to_device <= '0;
      rd_data        <= '0;
      rd_valid       <= 1'b0;
      ok             <= 1'b0;
      beats_done     <= '0;
    end else begin
      state    <= state_next;
      rd_valid <= 1'b0;
      if (accept) begin
        write_q        <= req_write;
        len_q          <= len_eff;
        data_to_device <= DATA_W'(req_addr);
        ok             <= 1'b0;
        beats_done     <= '0;
        beat           <= BEAT_ADDR;
        fresh          <= 1'b0;
      end
      if (wr_pop) begin
        data_to_device <= wr_data;
      end
      if (success) begin
        fresh <= 1'b1;
        if (state == ADDR) begin
          beat <= write_q ? BEAT_OUT : BEAT_IN;
        end else begin
          beats_done <= beats_done + LEN_W'(1);
          if (last_beat) ok <= 1'b1;
        end
        if (state == DATA_IN) begin
          rd_data  <= data_from_device;
          rd_valid <= 1'b1;
        end
      end else if (fail_any) begin
        fresh <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usb_rw_burst_engine.sv
// Directed bench for usb_rw_burst_engine: table of bursts with a small
// protocol responder, plus hand-written reset and timeout sequences.
module tb_usb_rw_burst_engine;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 16;
  localparam int LEN_W  = 3;

  logic              clk = 1'b0;
  logic              rst_b = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_pop;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [DATA_W-1:0] data_to_device;
  logic [DATA_W-1:0] data_from_device = '0;
  logic              out_trans;
  logic              in_trans;
  logic              txn_success = 1'b0;
  logic              txn_failure = 1'b0;
  logic              done;
  logic              ok;
  logic [LEN_W-1:0]  beats_done;

  int n_checks = 0;
  int n_fail   = 0;

  usb_rw_burst_engine #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .BURST_MAX  (4),
    .MAX_RETRY  (3),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_len         (req_len),
    .wr_data         (wr_data),
    .wr_pop          (wr_pop),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .data_to_device  (data_to_device),
    .data_from_device(data_from_device),
    .out_trans       (out_trans),
    .in_trans        (in_trans),
    .txn_success     (txn_success),
    .txn_failure     (txn_failure),
    .done            (done),
    .ok              (ok),
    .beats_done      (beats_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [2:0]  len;
    logic [3:0]  addr_fail;  // failures injected on the address transaction
    logic [3:0]  fail_beat;  // 1-based data beat to fail, 0 = none
    logic [3:0]  fail_n;     // failures injected on that beat
    logic        both;       // success and failure together on the address
    logic        silent;     // device never answers
    logic        exp_ok;
    logic [2:0]  exp_beats;
    logic [3:0]  exp_pops;
    logic [3:0]  exp_rd;
    logic [7:0]  exp_cyc;    // cycles from accept to done, 0 = unchecked
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_burst(input int idx, input vec_t v);
    int  pops   = 0;
    int  beats  = 0;
    int  rdn    = 0;
    int  afails = 0;
    int  dfails = 0;
    bit  addr_ph = 1'b1;
    bit  seen_done = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d req_ready idle", idx), 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_len   = v.len;
    @(negedge clk);
    req_valid = 1'b0;
    check($sformatf("v%0d req_ready busy", idx), 64'(req_ready), 64'd0);
    for (int c = 1; c <= 400 && !seen_done; c++) begin
      if (c > 1) @(negedge clk);
      txn_success      = 1'b0;
      txn_failure      = 1'b0;
      wr_data          = 64'(pops + 1);
      data_from_device = 64'hDEAD_BEEF + 64'(beats);
      if (rd_valid) begin
        rdn++;
        check($sformatf("v%0d rd_data", idx), rd_data, 64'hDEAD_BEEF + 64'(rdn - 1));
      end
      if (wr_pop) pops++;
      if (done) begin
        seen_done = 1'b1;
        check($sformatf("v%0d ok", idx), 64'(ok), 64'(v.exp_ok));
        check($sformatf("v%0d beats_done", idx), 64'(beats_done), 64'(v.exp_beats));
        check($sformatf("v%0d wr_pops", idx), 64'(pops), 64'(v.exp_pops));
        check($sformatf("v%0d rd_pulses", idx), 64'(rdn), 64'(v.exp_rd));
        if (v.exp_cyc != 0)
          check($sformatf("v%0d latency", idx), 64'(c), 64'(v.exp_cyc));
      end else if (out_trans || in_trans) begin
        if (addr_ph) begin
          check($sformatf("v%0d addr dir", idx), {62'd0, out_trans, in_trans}, 64'd2);
          check($sformatf("v%0d addr data", idx), data_to_device, 64'(v.addr));
        end else begin
          check($sformatf("v%0d data dir", idx), {62'd0, out_trans, in_trans},
                v.write ? 64'd2 : 64'd1);
          if (v.write)
            check($sformatf("v%0d out data", idx), data_to_device, 64'(pops));
        end
        if (v.silent) begin
          // no response
        end else if (addr_ph) begin
          if (afails < int'(v.addr_fail)) begin
            txn_failure = 1'b1;
            afails++;
          end else begin
            txn_success = 1'b1;
            txn_failure = v.both;
            addr_ph     = 1'b0;
          end
        end else if (beats + 1 == int'(v.fail_beat) && dfails < int'(v.fail_n)) begin
          txn_failure = 1'b1;
          dfails++;
        end else begin
          txn_success = 1'b1;
          beats++;
        end
      end
    end
    txn_success = 1'b0;
    txn_failure = 1'b0;
    if (!seen_done) begin
      check($sformatf("v%0d done within budget", idx), 64'd0, 64'd1);
    end else begin
      @(negedge clk);
      check($sformatf("v%0d done pulse width", idx), 64'(done), 64'd0);
      check($sformatf("v%0d ok held", idx), 64'(ok), 64'(v.exp_ok));
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [15:0] a, input logic [2:0] l,
                              input int af, input int fb, input int fn, input bit bo,
                              input bit si, input bit eok, input int eb, input int ep,
                              input int er, input int ec);
    vec_t v;
    v.write     = wr;
    v.addr      = a;
    v.len       = l;
    v.addr_fail = 4'(af);
    v.fail_beat = 4'(fb);
    v.fail_n    = 4'(fn);
    v.both      = bo;
    v.silent    = si;
    v.exp_ok    = eok;
    v.exp_beats = 3'(eb);
    v.exp_pops  = 4'(ep);
    v.exp_rd    = 4'(er);
    v.exp_cyc   = 8'(ec);
    return v;
  endfunction

  vec_t vecs[7];

  initial begin
    //             wr    addr      len   af fb fn both sil ok beats pops rd cyc
    vecs[0] = mk(1'b0, 16'h00A5, 3'd1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 4);
    vecs[1] = mk(1'b1, 16'h0010, 3'd3, 0, 0, 0, 0, 0, 1, 3, 3, 0, 8);
    vecs[2] = mk(1'b1, 16'h0020, 3'd3, 0, 2, 2, 0, 0, 1, 3, 3, 0, 12);
    vecs[3] = mk(1'b0, 16'h0030, 3'd4, 0, 3, 3, 0, 0, 0, 2, 0, 2, 12);
    vecs[4] = mk(1'b0, 16'h0040, 3'd0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 4);
    vecs[5] = mk(1'b1, 16'hFFFF, 3'd7, 0, 0, 0, 0, 0, 1, 4, 4, 0, 10);
    vecs[6] = mk(1'b0, 16'h1234, 3'd2, 2, 0, 0, 0, 0, 1, 2, 0, 2, 10);

    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset strobes", {58'd0, out_trans, in_trans, done, wr_pop, rd_valid, ok}, 64'd0);
    check("reset beats_done", 64'(beats_done), 64'd0);
    check("reset data_to_device", data_to_device, 64'd0);
    check("reset rd_data", rd_data, 64'd0);

    for (int i = 0; i < 7; i++) run_burst(i, vecs[i]);

`ifdef USB_RW_TIMEOUT_EN
    run_burst(7, mk(1'b0, 16'h0077, 3'd1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 27));
`endif

    // Reset in the middle of a write data beat.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h0050;
    req_len   = 3'd3;
    @(negedge clk);
    req_valid   = 1'b0;
    txn_success = 1'b1;
    @(negedge clk);
    txn_success = 1'b0;
    wr_data     = 64'h55;
    check("rst seq pop before reset", 64'(wr_pop), 64'd1);
    @(negedge clk);
    check("rst seq in data_out", {62'd0, out_trans, in_trans}, 64'd2);
    check("rst seq captured word", data_to_device, 64'h55);
    rst_b = 1'b0;
    @(negedge clk);
    check("rst seq req_ready", 64'(req_ready), 64'd1);
    check("rst seq strobes", {58'd0, out_trans, in_trans, done, wr_pop, rd_valid, ok}, 64'd0);
    check("rst seq beats_done", 64'(beats_done), 64'd0);
    check("rst seq data_to_device", data_to_device, 64'd0);
    check("rst seq rd_data", rd_data, 64'd0);
    rst_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst seq quiet after reset", {62'd0, done, wr_pop}, 64'd0);
    end

    run_burst(8, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global time limit: got expired, expected completion");
    $fatal(1, "time limit");
  end

endmodule
